// File: rtl/mux_bus_demux_pkg.sv
// Shared definitions for the receive-side bus demultiplexer.
// Phase encodings must stay in step with the 16-series mux select.
package mux_bus_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic PHASE_ADDR = 1'b0;
  localparam logic PHASE_DATA = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 24;
  localparam int DEFAULT_ADDR_INCR  = 4;

endpackage

// File: rtl/mux_bus_demux_if.sv
// Bus-side beats in, address/data pairs and error pulses out.
// master: the side driving beats and consuming pairs; slave: the demux.
interface mux_bus_demux_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 24
);
  logic [DataWidth-1:0] bus_in;
  logic                 bus_select;
  logic                 bus_valid;
  logic                 bus_ready;
  logic [AddrWidth-1:0] addr_out;
  logic [DataWidth-1:0] data_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 addr_err;
  logic                 proto_err;

  modport master (
    output bus_in, bus_select, bus_valid, out_ready,
    input  bus_ready, addr_out, data_out, out_valid, addr_err, proto_err
  );

  modport slave (
    input  bus_in, bus_select, bus_valid, out_ready,
    output bus_ready, addr_out, data_out, out_valid, addr_err, proto_err
  );
endinterface

// File: rtl/mux_bus_demux_addr_counter.sv
// Held-address register: load from an address beat, step by AddrIncr
// after each delivered burst pair. Wraps naturally at 2^AddrWidth.
module mux_addr_counter
  import mux_bus_demux_pkg::*;
#(
  parameter int AddrWidth = DEFAULT_ADDR_WIDTH,
  parameter int AddrIncr  = DEFAULT_ADDR_INCR
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [AddrWidth-1:0] load_addr,
  input  logic                 incr,
  output logic [AddrWidth-1:0] held_addr
);

  localparam logic [AddrWidth-1:0] INCR_STEP = AddrWidth'(AddrIncr);

  // Load has priority; the FSM never asks for both in one cycle anyway.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held_addr <= '0;
    end else if (load) begin
      held_addr <= load_addr;
    end else if (incr) begin
      held_addr <= held_addr + INCR_STEP;
    end
  end

endmodule

// File: rtl/mux_bus_demux.sv
// Receive-side demultiplexer: splits address and data beats from the shared
// bus, pairs them, hands pairs downstream, and continues bursts with
// auto-incremented addresses.
//
// state | meaning
// IDLE  | no address held; data beats are protocol errors
// ADDR  | address held; next data beat forms a pair
// OUT   | pair presented downstream, waiting for out_ready
module mux_bus_demux
  import mux_bus_demux_pkg::*;
#(
  parameter int DataWidth = DEFAULT_DATA_WIDTH,
  parameter int AddrWidth = DEFAULT_ADDR_WIDTH,
  parameter int AddrIncr  = DEFAULT_ADDR_INCR
) (
  input logic            clock,
  input logic            reset_n,
  mux_bus_demux_if.slave bus
);

  state_t state_q, state_d;

  logic [AddrWidth-1:0] held_addr;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] data_q;
  logic                 out_valid_q;
  logic                 addr_err_q, proto_err_q;

  logic beat_acc, addr_beat, data_beat, upper_nz;
  logic load_addr, incr_addr, capture, addr_err_d, proto_err_d;

  // Ready depends on the state register only; reset forces it low.
  assign bus.bus_ready = reset_n && (state_q != OUT);

  assign beat_acc  = bus.bus_valid && bus.bus_ready;
  assign addr_beat = beat_acc && (bus.bus_select == PHASE_ADDR);
  assign data_beat = beat_acc && (bus.bus_select == PHASE_DATA);
  assign upper_nz  = |bus.bus_in[DataWidth-1:AddrWidth];

  mux_addr_counter #(
    .AddrWidth (AddrWidth),
    .AddrIncr  (AddrIncr)
  ) u_addr_counter (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load_addr),
    .load_addr (bus.bus_in[AddrWidth-1:0]),
    .incr      (incr_addr),
    .held_addr (held_addr)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus counter/capture/error controls.
  always_comb begin
    state_d     = state_q;
    load_addr   = 1'b0;
    incr_addr   = 1'b0;
    capture     = 1'b0;
    proto_err_d = 1'b0;
    // Range check applies to every accepted address beat; it never blocks.
    addr_err_d  = addr_beat && upper_nz;
    case (state_q)
      IDLE: begin
        if (addr_beat) begin
          load_addr = 1'b1;
          state_d   = ADDR;
        end else if (data_beat) begin
          proto_err_d = 1'b1;
        end
      end
      ADDR: begin
        if (addr_beat) begin
          load_addr = 1'b1;
        end else if (data_beat) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_valid_q && bus.out_ready) begin
          incr_addr = 1'b1;
          state_d   = ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output pair registers and one-cycle error pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      addr_err_q  <= addr_err_d;
      proto_err_q <= proto_err_d;
      if (capture) begin
        addr_q      <= held_addr;
        data_q      <= bus.bus_in;
        out_valid_q <= 1'b1;
      end else if (incr_addr) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.addr_out  = addr_q;
  assign bus.data_out  = data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_mux_bus_demux.sv
module tb_mux_bus_demux;
  localparam int DW = 32;
  localparam int AW = 24;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mux_bus_demux_if #(.DataWidth(DW), .AddrWidth(AW)) bus_if ();

  mux_bus_demux #(.DataWidth(DW), .AddrWidth(AW), .AddrIncr(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pair bookkeeping from the protocol rules.
  bit          m_have_addr, m_pending, m_proto, m_aerr;
  int unsigned m_held, m_addr;
  logic [31:0] m_data;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_have_addr = 0; m_pending = 0; m_proto = 0; m_aerr = 0;
      m_held = 0; m_addr = 0; m_data = '0;
    end else begin
      m_proto = 0;
      m_aerr  = 0;
      if (m_pending) begin
        if (bus_if.out_ready) begin
          m_pending = 0;
          m_held = (m_held + 4) % (1 << 24);
        end
      end else if (bus_if.bus_valid) begin
        if (bus_if.bus_select == 1'b0) begin
          m_have_addr = 1;
          m_held = bus_if.bus_in % (1 << 24);
          m_aerr = (bus_if.bus_in / (1 << 24)) != 0;
        end else if (!m_have_addr) begin
          m_proto = 1;
        end else begin
          m_pending = 1;
          m_addr = m_held;
          m_data = bus_if.bus_in;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    check("bus_ready", 64'(bus_if.bus_ready), 64'(reset_n && !m_pending));
    check("out_valid", 64'(bus_if.out_valid), 64'(m_pending));
    check("proto_err", 64'(bus_if.proto_err), 64'(m_proto));
    check("addr_err",  64'(bus_if.addr_err),  64'(m_aerr));
    if (m_pending) begin
      check("addr_out", 64'(bus_if.addr_out), 64'(m_addr));
      check("data_out", 64'(bus_if.data_out), 64'(m_data));
    end
  end

  // Handshake log and pulse counting, from DUT outputs.
  int          cyc = 0;
  logic [55:0] got[$];
  int          hs_cyc[$];
  int          proto_cycles = 0;
  int          aerr_cycles  = 0;

  always @(posedge clock) begin
    cyc++;
    if (reset_n) begin
      if (bus_if.out_valid && bus_if.out_ready) begin
        got.push_back({bus_if.addr_out, bus_if.data_out});
        hs_cyc.push_back(cyc);
      end
      if (bus_if.proto_err) proto_cycles++;
      if (bus_if.addr_err)  aerr_cycles++;
    end
  end

  task automatic beat(input logic sel, input logic [31:0] v);
    int n = 0;
    @(negedge clock); #1;
    bus_if.bus_valid  = 1'b1;
    bus_if.bus_select = sel;
    bus_if.bus_in     = v;
    while (!bus_if.bus_ready && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    if (n >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL beat_timeout: got bus_ready 0 expected 1");
    end else begin
      @(posedge clock);
    end
    #1 bus_if.bus_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clock); #1 reset_n = 1'b0;
    @(negedge clock); #1 reset_n = 1'b1;
  endtask

  initial begin
    bus_if.bus_valid  = 1'b1;
    bus_if.bus_select = 1'b0;
    bus_if.bus_in     = 32'hA5A5A5A5;
    bus_if.out_ready  = 1'b0;

    // Reset held with a beat on the bus
    idle(3);
    check("rst_bus_ready", 64'(bus_if.bus_ready), 64'd0);
    check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_addr_out",  64'(bus_if.addr_out),  64'd0);
    check("rst_data_out",  64'(bus_if.data_out),  64'd0);
    check("rst_errs",      64'({bus_if.addr_err, bus_if.proto_err}), 64'd0);
    bus_if.bus_valid = 1'b0;
    reset_n = 1'b1;
    #1 check("rel_bus_ready", 64'(bus_if.bus_ready), 64'd1);

    // Single pair, stalled downstream
    beat(1'b0, 32'h00123456);
    beat(1'b1, 32'hDEADBEEF);
    idle(1);
    check("single_valid", 64'(bus_if.out_valid), 64'd1);
    check("single_addr",  64'(bus_if.addr_out),  64'h123456);
    check("single_data",  64'(bus_if.data_out),  64'hDEADBEEF);
    idle(3);
    check("stall_ready",  64'(bus_if.bus_ready), 64'd0);
    check("stall_valid",  64'(bus_if.out_valid), 64'd1);
    bus_if.out_ready = 1'b1;
    idle(1);
    bus_if.out_ready = 1'b0;
    idle(1);
    check("single_count", 64'(got.size()), 64'd1);
    check("single_pair",  64'(got[0]), {24'h123456, 32'hDEADBEEF});

    // Burst continuation, downstream always ready
    bus_if.out_ready = 1'b1;
    beat(1'b1, 32'h11111111);
    beat(1'b1, 32'h22222222);
    idle(3);
    check("burst_count", 64'(got.size()), 64'd3);
    check("burst_pair1", 64'(got[1]), {24'h12345A, 32'h11111111});
    check("burst_pair2", 64'(got[2]), {24'h12345E, 32'h22222222});
    check("burst_spacing", 64'(hs_cyc[2] - hs_cyc[1]), 64'd2);

    // Address wrap
    beat(1'b0, 32'h00FFFFFC);
    beat(1'b1, 32'hCAFE0001);
    beat(1'b1, 32'hCAFE0002);
    idle(3);
    check("wrap_count", 64'(got.size()), 64'd5);
    check("wrap_pair1", 64'(got[3]), {24'hFFFFFC, 32'hCAFE0001});
    check("wrap_pair2", 64'(got[4]), {24'h000000, 32'hCAFE0002});
    check("wrap_no_err", 64'(proto_cycles + aerr_cycles), 64'd0);

    // Protocol error: data beat with no address held
    pulse_reset();
    beat(1'b1, 32'h00000055);
    idle(3);
    check("proto_cycles", 64'(proto_cycles), 64'd1);
    check("proto_no_pair", 64'(got.size()), 64'd5);

    // Address range error; truncated address still used
    beat(1'b0, 32'hAB000010);
    idle(2);
    check("aerr_cycles", 64'(aerr_cycles), 64'd1);
    beat(1'b1, 32'h00000099);
    idle(2);
    check("aerr_pair", 64'(got[5]), {24'h000010, 32'h00000099});

    // Reset while a pair is pending
    bus_if.out_ready = 1'b0;
    beat(1'b0, 32'h00000040);
    beat(1'b1, 32'h00000077);
    idle(1);
    check("pend_valid", 64'(bus_if.out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_valid", 64'(bus_if.out_valid), 64'd0);
    check("async_addr",  64'(bus_if.addr_out),  64'd0);
    check("async_ready", 64'(bus_if.bus_ready), 64'd0);
    idle(2);
    reset_n = 1'b1;
    beat(1'b1, 32'h00000005);
    idle(3);
    check("post_rst_proto", 64'(proto_cycles), 64'd2);
    check("post_rst_pairs", 64'(got.size()), 64'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
